score_keeper: RTL

//  Owns the 14-bit game score and shares it among N_REQ point sources (egg catch, bonus, combo ...).

---
 rtl/score_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/score_keeper.sv | 102 ++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and arithmetic for the score keeper: score width, ceiling,
// conversion FSM states and the saturating adder.
package score_pkg;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] MAX_SCORE = 14'd9999;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_START,
    CONV_GUARD,
    CONV_WAIT
  } conv_state_e;

  // One bit wider than the score so an overflow past 2^14 still clamps.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                 input logic [SCORE_W-1:0] delta);
    logic [SCORE_W:0] sum;
    sum = {1'b0, base} + {1'b0, delta};
    return (sum > {1'b0, MAX_SCORE}) ? MAX_SCORE : sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping, plus the pointer value that follows the winner.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] winner_o,
  output logic             valid_o,
  output logic [PTR_W-1:0] next_ptr_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    winner_o   = '0;
    valid_o    = 1'b0;
    next_ptr_o = ptr_i;
    idx        = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
        next_ptr_o    = (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score owner: round-robin increments from N_REQ sources with saturation,
// high-score tracking, and coalesced start pulses to the binary2bcd converter.
module score_keeper
  import score_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int INC_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*INC_W-1:0] inc,
  input  logic                   clear,
  input  logic                   bcd_ready,
  output logic [N_REQ-1:0]       grant,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     hi_score,
  output logic                   new_score,
  output logic                   busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]   grant_q, masked_req, winner;
  logic               win_valid;
  logic [PTR_W-1:0]   ptr_q, next_ptr;
  logic [SCORE_W-1:0] score_q, score_d, hi_q, win_inc;
  logic               dirty_q, new_score_q, start_fire;
  conv_state_e        state_q;

  // Last cycle's grantee is masked while its request is still falling.
  assign masked_req = req & ~grant_q;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req_i      (masked_req),
    .ptr_i      (ptr_q),
    .winner_o   (winner),
    .valid_o    (win_valid),
    .next_ptr_o (next_ptr)
  );

  always_comb begin
    win_inc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) win_inc = SCORE_W'(inc[i*INC_W +: INC_W]);
    end
  end

  always_comb begin
    score_d = score_q;
    if (clear)          score_d = '0;
    else if (win_valid) score_d = sat_add(score_q, win_inc);
  end

  assign start_fire = (state_q == CONV_IDLE) && dirty_q && bcd_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      hi_q    <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      score_q <= score_d;
      grant_q <= clear ? '0 : winner;
      if (!clear && win_valid) ptr_q <= next_ptr;
      if (score_q > hi_q)      hi_q  <= score_q;
      dirty_q <= (score_d != score_q) || (dirty_q && !start_fire);
    end
  end

  // GUARD skips one cycle of bcd_ready because the converter drops it late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CONV_IDLE;
      new_score_q <= 1'b0;
    end else begin
      new_score_q <= 1'b0;
      case (state_q)
        CONV_IDLE: begin
          if (start_fire) begin
            state_q     <= CONV_START;
            new_score_q <= 1'b1;
          end
        end
        CONV_START: state_q <= CONV_GUARD;
        CONV_GUARD: state_q <= CONV_WAIT;
        CONV_WAIT:  if (bcd_ready) state_q <= CONV_IDLE;
        default:    state_q <= CONV_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign score     = score_q;
  assign hi_score  = hi_q;
  assign new_score = new_score_q;
  assign busy      = (state_q != CONV_IDLE) || dirty_q;

endmodule
